// File: rtl/uart_rx_blk.sv
// 8N1 UART receiver: synchronizes RX, centre-samples each bit and hands bytes to the consumer
// through rx_data/rdy, with false-start rejection, framing-error and overrun flags.
module uart_rx_blk #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0] L_HALF_LOAD = 12'(HALF_DIV - 1);
  localparam logic [11:0] L_BAUD_LOAD = 12'(BAUD_DIV - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_rxMeta;
  logic        r_rxS;
  logic        r_rxPrev;
  logic [11:0] r_baudCnt;
  logic [3:0]  r_bitCnt;
  logic [7:0]  r_shift;
  logic        w_fall;
  logic        w_sample;
  logic        w_shiftEn;
  logic        w_clrFrm;
  logic        w_setFrm;
  logic        w_setRdy;

  assign w_fall   = r_rxPrev & ~r_rxS;
  assign w_sample = (r_baudCnt == 12'd0);

  // r_rxPrev holds the previous synchronized value so a falling edge is seen only once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxMeta <= RX;
      r_rxS    <= r_rxMeta;
      r_rxPrev <= r_rxS;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:  if (w_fall) w_nextState = START;
      START: if (w_sample) w_nextState = r_rxS ? IDLE : DATA;
      DATA:  if (w_sample && (r_bitCnt == 4'd7)) w_nextState = STOP;
      STOP:  if (w_sample) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_shiftEn = (r_state == DATA)  && w_sample;
    w_clrFrm  = (r_state == START) && w_sample && !r_rxS;
    w_setRdy  = (r_state == STOP)  && w_sample &&  r_rxS;
    w_setFrm  = (r_state == STOP)  && w_sample && !r_rxS;
  end

  // The counter parks at zero in IDLE and reloads on every sample so each bit is centre-sampled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_baudCnt <= 12'd0;
    end else if (r_state == IDLE) begin
      r_baudCnt <= w_fall ? L_HALF_LOAD : 12'd0;
    end else if (w_sample) begin
      r_baudCnt <= (w_nextState == IDLE) ? 12'd0 : L_BAUD_LOAD;
    end else begin
      r_baudCnt <= r_baudCnt - 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitCnt <= 4'd0;
      r_shift  <= 8'h00;
    end else if (w_clrFrm) begin
      r_bitCnt <= 4'd0;
    end else if (w_shiftEn) begin
      r_bitCnt <= r_bitCnt + 4'd1;
      r_shift  <= {r_rxS, r_shift[7:1]};
    end
  end

  // A new byte beats a simultaneous clr_rdy; overrun only when the old byte was never acknowledged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      if (w_setRdy) begin
        rx_data <= r_shift;
        rdy     <= 1'b1;
      end else if (clr_rdy) begin
        rdy     <= 1'b0;
      end

      if (w_setRdy && rdy && !clr_rdy) ovr_err <= 1'b1;
      else if (clr_rdy)                ovr_err <= 1'b0;

      if (w_setFrm)      frm_err <= 1'b1;
      else if (w_clrFrm) frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_blk.sv
// Self-checking bench for uart_rx_blk: frames are driven bit by bit and outputs are compared
// with a frame-level model of what the consumer should see.
module tb_uart_rx_blk;
  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  int testsRun = 0;
  int failures = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  int riseCycle = -1;
  int measLat = 155;
  logic prevRdy = 1'b0;

  logic [7:0] mData;
  logic       mRdy;
  logic       mFrm;
  logic       mOvr;

  uart_rx_blk #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin
    if (rdy && !prevRdy) riseCycle = cycleCnt;
    prevRdy = rdy;
  end

  task automatic model_reset();
    mData = 8'h00; mRdy = 1'b0; mFrm = 1'b0; mOvr = 1'b0;
  endtask

  task automatic bit_time(input logic v);
    RX = v;
    repeat (BAUD) @(negedge clk);
  endtask

  // A frame whose stop bit is good delivers its byte; a bad stop only raises frm_err
  task automatic send_frame(input logic [7:0] d, input logic stopBit);
    startCycle = cycleCnt;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stopBit);
    RX = 1'b1;
    if (!stopBit) repeat (BAUD) @(negedge clk);
    mFrm = 1'b0;
    if (stopBit) begin
      if (mRdy) mOvr = 1'b1;
      mData = d;
      mRdy  = 1'b1;
    end else begin
      mFrm = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    mRdy = 1'b0;
    mOvr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    testsRun++;
    if ({rx_data, rdy, frm_err, ovr_err} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got data=%h rdy=%b frm=%b ovr=%b, want all zero",
               rx_data, rdy, frm_err, ovr_err);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1);
    measLat = riseCycle - startCycle;
    testsRun++;
    if (riseCycle < 0 || measLat < 153 || measLat > 155) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d cycles, want 153..155", measLat);
      measLat = 155;
    end
    testsRun++;
    if (rx_data !== 8'hA5 || rdy !== 1'b1 || frm_err !== 1'b0 || ovr_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_byte: got data=%h rdy=%b frm=%b ovr=%b, want A5 1 0 0",
               rx_data, rdy, frm_err, ovr_err);
    end
    pulse_clr();
    testsRun++;
    if (rdy !== 1'b0 || rx_data !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL basic_clr: got rdy=%b data=%h, want 0 A5", rdy, rx_data);
    end
  endtask

  task automatic test_glitch();
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    testsRun++;
    if (rx_data !== mData || rdy !== mRdy || frm_err !== mFrm || ovr_err !== mOvr) begin
      failures++;
      $display("[TB] FAIL glitch_ignored: got %h %b %b %b, want %h %b %b %b",
               rx_data, rdy, frm_err, ovr_err, mData, mRdy, mFrm, mOvr);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    testsRun++;
    if (frm_err !== 1'b1 || rdy !== 1'b0 || rx_data !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL frame_bad_stop: got frm=%b rdy=%b data=%h, want 1 0 A5",
               frm_err, rdy, rx_data);
    end
    send_frame(8'h0F, 1'b1);
    testsRun++;
    if (frm_err !== 1'b0 || rdy !== 1'b1 || rx_data !== 8'h0F) begin
      failures++;
      $display("[TB] FAIL frame_recover: got frm=%b rdy=%b data=%h, want 0 1 0F",
               frm_err, rdy, rx_data);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    testsRun++;
    if (rx_data !== 8'h22 || rdy !== 1'b1 || ovr_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_overrun: got data=%h rdy=%b ovr=%b, want 22 1 1",
               rx_data, rdy, ovr_err);
    end
    pulse_clr();
    testsRun++;
    if (rdy !== 1'b0 || ovr_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_clear: got rdy=%b ovr=%b, want 0 0", rdy, ovr_err);
    end
  endtask

  task automatic test_clr_at_stop();
    send_frame(8'h44, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (measLat - 1) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    mOvr = 1'b0;
    testsRun++;
    if (rdy !== 1'b1 || rx_data !== 8'h55 || ovr_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clr_at_stop: got rdy=%b data=%h ovr=%b, want 1 55 0",
               rdy, rx_data, ovr_err);
    end
  endtask

  task automatic test_reset_mid();
    startCycle = cycleCnt;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    testsRun++;
    if ({rx_data, rdy, frm_err, ovr_err} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got %h %b %b %b, want all zero",
               rx_data, rdy, frm_err, ovr_err);
    end
    repeat (7 * BAUD) @(negedge clk);
    testsRun++;
    if (rdy !== 1'b0 || frm_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_byte: got rdy=%b frm=%b, want 0 0", rdy, frm_err);
    end
    send_frame(8'h81, 1'b1);
    testsRun++;
    if (rx_data !== 8'h81 || rdy !== 1'b1 || ovr_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_next: got data=%h rdy=%b ovr=%b, want 81 1 0",
               rx_data, rdy, ovr_err);
    end
  endtask

  task automatic test_break();
    RX = 1'b0;
    repeat (15 * BAUD) @(negedge clk);
    mFrm = 1'b1;
    testsRun++;
    if (frm_err !== 1'b1 || rdy !== mRdy || rx_data !== mData) begin
      failures++;
      $display("[TB] FAIL break_frame: got frm=%b rdy=%b data=%h, want 1 %b %h",
               frm_err, rdy, rx_data, mRdy, mData);
    end
    RX = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    pulse_clr();
    send_frame(8'hC3, 1'b1);
    testsRun++;
    if (rx_data !== 8'hC3 || rdy !== 1'b1 || frm_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL break_recover: got data=%h rdy=%b frm=%b, want C3 1 0",
               rx_data, rdy, frm_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       good;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good);
      testsRun++;
      if (rx_data !== mData || rdy !== mRdy || frm_err !== mFrm || ovr_err !== mOvr) begin
        failures++;
        $display("[TB] FAIL random_frame%0d: sent %h stop=%b got %h %b %b %b, want %h %b %b %b",
                 n, d, good, rx_data, rdy, frm_err, ovr_err, mData, mRdy, mFrm, mOvr);
      end
      if ($urandom_range(0, 1) == 1) pulse_clr();
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_clr_at_stop();
    test_reset_mid();
    test_break();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
